lane_add_sub: RTL

- Multi-lane successor to the single-lane adder.
- Accepts one vector transaction per handshake (LANES lanes of DATA_WIDTH bits) and applies a per-transaction op (wrap add, wrap sub, saturating add, saturating sub) to every lane.
- Buffers results in a 2-entry output queue drained by the downstream FIFO read enable.
- Sits between input operand FIFOs and the result FIFO in the datapath.

---
 rtl/lane_add_sub_if.sv | 27 ++
 rtl/lane_add_sub.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lane_add_sub_if.sv
// Handshake and data bundle for lane_add_sub: operand intake on one side,
// result queue head and overflow statistics on the other.
interface lane_add_sub_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  op;
    logic [LANES*DATA_WIDTH-1:0] addend_a;
    logic [LANES*DATA_WIDTH-1:0] addend_b;
    logic [LANES*DATA_WIDTH-1:0] result;
    logic [LANES-1:0]            overflow;
    logic                        out_valid;
    logic                        out_rd_en;
    logic [15:0]                 ovf_count;

    modport master (
        output in_valid, op, addend_a, addend_b, out_rd_en,
        input  in_ready, result, overflow, out_valid, ovf_count
    );

    modport slave (
        input  in_valid, op, addend_a, addend_b, out_rd_en,
        output in_ready, result, overflow, out_valid, ovf_count
    );
endinterface

// File: rtl/lane_add_sub.sv
// Multi-lane wrap/saturating add/sub with a 2-entry result queue and a
// saturating count of overflowed lanes.
module lane_add_sub #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int SIGNED     = 0
) (
    input logic          clock,
    input logic          reset,
    lane_add_sub_if.slave bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]         state_q;
    logic               live_q;
    logic [LANES*W-1:0] res0_q, res1_q;
    logic [LANES-1:0]   ovf0_q, ovf1_q;
    logic [15:0]        ovf_count_q;

    logic               accept, pop;
    logic               sub_op, sat_op, lane_ovf;
    logic [W-1:0]       a_l, b_l, r_l;
    logic [W:0]         wide;
    logic [LANES*W-1:0] new_res;
    logic [LANES-1:0]   new_ovf;
    logic [16:0]        ovf_pop, ovf_sum;
    logic [15:0]        ovf_count_next;

    // Ready is decoded only from registered state so out_rd_en never reaches it.
    assign bus.in_ready  = live_q && (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.result    = res0_q;
    assign bus.overflow  = ovf0_q;
    assign bus.ovf_count = ovf_count_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_rd_en;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        sub_op   = bus.op[0];
        sat_op   = bus.op[1];
        a_l      = '0;
        b_l      = '0;
        r_l      = '0;
        wide     = '0;
        lane_ovf = 1'b0;
        new_res  = '0;
        new_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_l  = bus.addend_a[i*W +: W];
            b_l  = bus.addend_b[i*W +: W];
            wide = sub_op ? ({1'b0, a_l} - {1'b0, b_l}) : ({1'b0, a_l} + {1'b0, b_l});
            if (SIGNED != 0) begin
                // Overflow direction always follows the sign of operand a.
                lane_ovf = (sub_op ? (a_l[W-1] != b_l[W-1]) : (a_l[W-1] == b_l[W-1]))
                           && (wide[W-1] != a_l[W-1]);
                r_l = a_l[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                lane_ovf = wide[W];
                r_l      = sub_op ? '0 : '1;
            end
            if (!(sat_op && lane_ovf)) begin
                r_l = wide[W-1:0];
            end
            new_res[i*W +: W] = r_l;
            new_ovf[i]        = lane_ovf;
        end
    end

    always_comb begin
        ovf_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            ovf_pop = ovf_pop + 17'(new_ovf[i]);
        end
        ovf_sum        = {1'b0, ovf_count_q} + ovf_pop;
        ovf_count_next = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    // NOTE: the queue storage is reset too, because result/overflow must read 0 during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            live_q      <= 1'b0;
            res0_q      <= '0;
            res1_q      <= '0;
            ovf0_q      <= '0;
            ovf1_q      <= '0;
            ovf_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            live_q <= 1'b1;
            if (accept) begin
                ovf_count_q <= ovf_count_next;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        res0_q  <= new_res;
                        ovf0_q  <= new_ovf;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        res0_q <= new_res;
                        ovf0_q <= new_ovf;
                    end else if (accept) begin
                        res1_q  <= new_res;
                        ovf1_q  <= new_ovf;
                        state_q <= FULL;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        res0_q  <= res1_q;
                        ovf0_q  <= ovf1_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule
